// File: rtl/fft8_pkg.sv
// Shared constants, twiddle table, FSM state type and index helper for the 8-point FFT.
// Build option FFT8_IFFT_EN (see fft_8) consumes these unchanged.
package fft8_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned TW_W_DEF  = 16;

   typedef enum logic [1:0] {StIdle, StS1, StS2, StDone} state_e;

   typedef struct packed {
      int re;
      int im;
   } tw_t;

   // round(2^(tw_w-1) / sqrt(2)) from a 2^22-scaled constant; valid for tw_w in 2..22
   function automatic int tw_c(int unsigned tw_w);
      longint      num;
      int unsigned sh;
      num = 64'd2965821;
      sh  = 23 - tw_w;
      return int'((num + (longint'(1) << (sh - 1))) >>> sh);
   endfunction

   function automatic tw_t twiddle(int unsigned tw_w, logic [1:0] k);
      tw_t t;
      int  c;
      c = tw_c(tw_w);
      case (k)
         2'd0:    begin t.re = int'(1) << (tw_w - 1); t.im = 0; end
         2'd1:    begin t.re = c;                     t.im = -c; end
         2'd2:    begin t.re = 0;                     t.im = -(int'(1) << (tw_w - 1)); end
         default: begin t.re = -c;                    t.im = -c; end
      endcase
      return t;
   endfunction

   function automatic logic [2:0] bit_rev(logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

   localparam int  C  = tw_c(TW_W_DEF);
   localparam tw_t W0 = twiddle(TW_W_DEF, 2'd0);
   localparam tw_t W1 = twiddle(TW_W_DEF, 2'd1);
   localparam tw_t W2 = twiddle(TW_W_DEF, 2'd2);
   localparam tw_t W3 = twiddle(TW_W_DEF, 2'd3);

endpackage

// File: rtl/fft8_butterfly.sv
// Radix-2 DIT butterfly: p = a + W*b, m = a - W*b, one bit wider than the inputs.
// With FFT8_IFFT_EN a conj input selects the conjugate twiddle.
module fft8_butterfly
   import fft8_pkg::*;
#(
   parameter int unsigned W    = 16,
   parameter int unsigned TW_W = 16
) (
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   input  logic [1:0]          tw_sel,
`ifdef FFT8_IFFT_EN
   input  logic                conj,
`endif
   output logic signed [W:0]   p_re,
   output logic signed [W:0]   p_im,
   output logic signed [W:0]   m_re,
   output logic signed [W:0]   m_im
);

   localparam int unsigned PW = W + TW_W + 1;
   localparam tw_t TW1 = twiddle(TW_W, 2'd1);
   localparam tw_t TW3 = twiddle(TW_W, 2'd3);
   localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_W - 2));

   logic signed [TW_W-1:0] wr, wi;
   logic signed [PW-1:0]   pr, pi;
   logic signed [W:0]      br, bi, tr, ti;
   logic                   cj;

   always_comb begin
`ifdef FFT8_IFFT_EN
      cj = conj;
`else
      cj = 1'b0;
`endif
      br = (W + 1)'(b_re);
      bi = (W + 1)'(b_im);
      wr = TW_W'(TW1.re);
      wi = TW_W'(TW1.im);
      if (tw_sel == 2'd3) begin
         wr = TW_W'(TW3.re);
         wi = TW_W'(TW3.im);
      end
      if (cj) wi = -wi;
      pr = PW'(b_re) * PW'(wr) - PW'(b_im) * PW'(wi);
      pi = PW'(b_re) * PW'(wi) + PW'(b_im) * PW'(wr);
      case (tw_sel)
         2'd0: begin
            tr = br;
            ti = bi;
         end
         // -j (or +j when conjugated) is a swap with one negation
         2'd2: begin
            tr = cj ? -bi : bi;
            ti = cj ? br  : -br;
         end
         default: begin
            tr = (W + 1)'((pr + RND) >>> (TW_W - 1));
            ti = (W + 1)'((pi + RND) >>> (TW_W - 1));
         end
      endcase
      p_re = (W + 1)'(a_re) + tr;
      p_im = (W + 1)'(a_im) + ti;
      m_re = (W + 1)'(a_re) - tr;
      m_im = (W + 1)'(a_im) - ti;
   end

endmodule

// File: rtl/fft_8.sv
// 8-point radix-2 DIT FFT, one butterfly stage per clock, start/done handshake.
// Define FFT8_IFFT_EN to add the 'inverse' input (conjugate twiddles, unscaled IDFT).
module fft_8
   import fft8_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned TW_W  = TW_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
`ifdef FFT8_IFFT_EN
   input  logic                     inverse,
`endif
   input  logic [8*WIDTH-1:0]       x_re,
   input  logic [8*WIDTH-1:0]       x_im,
   output logic                     busy,
   output logic                     done,
   output logic [8*(WIDTH+3)-1:0]   y_re,
   output logic [8*(WIDTH+3)-1:0]   y_im
);

   localparam int unsigned S1W = WIDTH + 1;
   localparam int unsigned S2W = WIDTH + 2;
   localparam int unsigned S3W = WIDTH + 3;

   state_e state_q, state_d;

   logic signed [WIDTH-1:0] xb_re [8], xb_im [8];
   logic signed [S1W-1:0]   s1_d_re [8], s1_d_im [8], s1_q_re [8], s1_q_im [8];
   logic signed [S2W-1:0]   s2_d_re [8], s2_d_im [8], s2_q_re [8], s2_q_im [8];
   logic signed [S3W-1:0]   s3_d_re [8], s3_d_im [8], y_q_re [8], y_q_im [8];
   logic                    inv_q;

`ifdef FFT8_IFFT_EN
   logic inv_d;
   assign inv_d = inverse;
`else
   logic inv_d;
   assign inv_d = 1'b0;
`endif

   always_comb begin
      for (int n = 0; n < 8; n++) begin
         xb_re[n] = x_re[int'(bit_rev(3'(n)))*WIDTH +: WIDTH];
         xb_im[n] = x_im[int'(bit_rev(3'(n)))*WIDTH +: WIDTH];
      end
   end

   // Stage 1: adjacent pairs, W0 only. Stage 2: span 2, W0/W2. Stage 3: span 4, W0..W3.
   for (genvar i = 0; i < 4; i++) begin : g_st1
      fft8_butterfly #(.W(WIDTH), .TW_W(TW_W)) u_bf (
         .a_re  (xb_re[2*i]),     .a_im (xb_im[2*i]),
         .b_re  (xb_re[2*i+1]),   .b_im (xb_im[2*i+1]),
         .tw_sel(2'd0),
`ifdef FFT8_IFFT_EN
         .conj  (inv_d),
`endif
         .p_re  (s1_d_re[2*i]),   .p_im (s1_d_im[2*i]),
         .m_re  (s1_d_re[2*i+1]), .m_im (s1_d_im[2*i+1])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_st2
      localparam int T = 4 * (i / 2) + (i % 2);
      fft8_butterfly #(.W(S1W), .TW_W(TW_W)) u_bf (
         .a_re  (s1_q_re[T]),   .a_im (s1_q_im[T]),
         .b_re  (s1_q_re[T+2]), .b_im (s1_q_im[T+2]),
         .tw_sel((i % 2 == 1) ? 2'd2 : 2'd0),
`ifdef FFT8_IFFT_EN
         .conj  (inv_q),
`endif
         .p_re  (s2_d_re[T]),   .p_im (s2_d_im[T]),
         .m_re  (s2_d_re[T+2]), .m_im (s2_d_im[T+2])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_st3
      fft8_butterfly #(.W(S2W), .TW_W(TW_W)) u_bf (
         .a_re  (s2_q_re[i]),   .a_im (s2_q_im[i]),
         .b_re  (s2_q_re[i+4]), .b_im (s2_q_im[i+4]),
         .tw_sel(2'(i)),
`ifdef FFT8_IFFT_EN
         .conj  (inv_q),
`endif
         .p_re  (s3_d_re[i]),   .p_im (s3_d_im[i]),
         .m_re  (s3_d_re[i+4]), .m_im (s3_d_im[i+4])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = StS1;
      end else begin
         case (state_q)
            StS1:    state_d = StS2;
            StS2:    state_d = StDone;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == StS1) || (state_q == StS2);
      done = (state_q == StDone);
   end

   // A start in flight abandons the older computation, so later stages only advance without it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inv_q <= 1'b0;
         for (int n = 0; n < 8; n++) begin
            s1_q_re[n] <= '0;
            s1_q_im[n] <= '0;
            s2_q_re[n] <= '0;
            s2_q_im[n] <= '0;
            y_q_re[n]  <= '0;
            y_q_im[n]  <= '0;
         end
      end else begin
         if (start) begin
            inv_q   <= inv_d;
            s1_q_re <= s1_d_re;
            s1_q_im <= s1_d_im;
         end
         if (!start && state_q == StS1) begin
            s2_q_re <= s2_d_re;
            s2_q_im <= s2_d_im;
         end
         if (!start && state_q == StS2) begin
            y_q_re <= s3_d_re;
            y_q_im <= s3_d_im;
         end
      end
   end

   always_comb begin
      y_re = '0;
      y_im = '0;
      for (int k = 0; k < 8; k++) begin
         y_re[k*S3W +: S3W] = y_q_re[k];
         y_im[k*S3W +: S3W] = y_q_im[k];
      end
   end

endmodule

// File: tb/tb_fft_8.sv
// Directed-vector bench for fft_8 (forward transform, default build).
module tb_fft_8;

   localparam int WIDTH = 16;
   localparam int YW    = WIDTH + 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [8*WIDTH-1:0]    x_re, x_im;
   logic                  busy, done;
   logic [8*YW-1:0]       y_re, y_im;

   int     n_chk  = 0;
   int     n_pass = 0;
   longint xr [8], xi [8], er [8], ei [8];

   always #5 clk = ~clk;

   fft_8 #(.WIDTH(WIDTH), .TW_W(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .x_re (x_re),
      .x_im (x_im),
      .busy (busy),
      .done (done),
      .y_re (y_re),
      .y_im (y_im)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic longint y_at(input logic [8*YW-1:0] v, input int k);
      logic signed [YW-1:0] t;
      t = v[k*YW +: YW];
      return longint'(t);
   endfunction

   task automatic check_y(input string tag);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s X%0d.re", tag, k), y_at(y_re, k), er[k]);
         check($sformatf("%s X%0d.im", tag, k), y_at(y_im, k), ei[k]);
      end
   endtask

   task automatic set_x(input longint r, input longint i);
      for (int n = 0; n < 8; n++) begin
         xr[n] = r;
         xi[n] = i;
      end
   endtask

   task automatic set_e(input longint r, input longint i);
      for (int k = 0; k < 8; k++) begin
         er[k] = r;
         ei[k] = i;
      end
   endtask

   // Drives start across one rising edge; returns #1 after that edge
   task automatic pulse_start();
      @(negedge clk);
      for (int n = 0; n < 8; n++) begin
         x_re[n*WIDTH +: WIDTH] = WIDTH'(xr[n]);
         x_im[n*WIDTH +: WIDTH] = WIDTH'(xi[n]);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x_re  = '1;
      x_im  = '1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag);
      int cyc;
      pulse_start();
      cyc = 0;
      while (!done && cyc < 8) begin
         step();
         cyc++;
      end
      check({tag, " done"}, longint'(done), 1);
      check_y(tag);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      x_re  = '0;
      x_im  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", longint'(busy), 0);
      check("reset done", longint'(done), 0);
      set_e(0, 0);
      check_y("reset");
      @(negedge clk);
      rst = 1'b1;
      step();
      check("idle done", longint'(done), 0);

      // Impulse at x0, with exact latency checks
      set_x(0, 0);
      xr[0] = 1000;
      pulse_start();
      check("lat N busy", longint'(busy), 1);
      check("lat N done", longint'(done), 0);
      step();
      check("lat N+1 busy", longint'(busy), 1);
      check("lat N+1 done", longint'(done), 0);
      step();
      check("lat N+2 busy", longint'(busy), 0);
      check("lat N+2 done", longint'(done), 1);
      set_e(1000, 0);
      check_y("impulse");

      // Constant input, then hold
      set_x(100, 0);
      set_e(0, 0);
      er[0] = 800;
      run("dc");
      repeat (4) step();
      check("dc hold done", longint'(done), 1);
      check_y("dc hold");

      // Impulse at x1 exercises every twiddle
      set_x(0, 0);
      xr[1] = 1000;
      er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
      ei = '{0, -707, -1000, -707, 0, 707, 1000, 707};
      run("shift");

      // Alternating sign lands entirely in X4
      for (int n = 0; n < 8; n++) begin
         xr[n] = (n % 2 == 0) ? 100 : -100;
         xi[n] = 0;
      end
      set_e(0, 0);
      er[4] = 800;
      run("alt");

      // Full-scale negative exercises full width growth
      set_x(-32768, 0);
      set_e(0, 0);
      er[0] = -262144;
      run("fullscale");

      // Restart from DONE
      set_x(0, 0);
      xi[0] = 500;
      pulse_start();
      check("restart N done", longint'(done), 0);
      check("restart N busy", longint'(busy), 1);
      step();
      check("restart N+1 done", longint'(done), 0);
      step();
      check("restart N+2 done", longint'(done), 1);
      set_e(0, 500);
      check_y("restart");

      // Second start during S1 replaces the first computation
      set_x(0, 0);
      xr[1] = 1000;
      pulse_start();
      set_x(-200, 300);
      xr[0] = -200;
      set_x(0, 0);
      xr[0] = -200;
      xi[0] = 300;
      pulse_start();
      check("s1 restart busy", longint'(busy), 1);
      check("s1 restart done", longint'(done), 0);
      step();
      check("s1 restart N+1 done", longint'(done), 0);
      step();
      check("s1 restart N+2 done", longint'(done), 1);
      set_e(-200, 300);
      check_y("s1 restart");

      // Asynchronous reset while in S2
      set_x(0, 0);
      xr[0] = 1000;
      pulse_start();
      step();
      check("pre-reset busy", longint'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      check("async rst busy", longint'(busy), 0);
      check("async rst done", longint'(done), 0);
      set_e(0, 0);
      check_y("async rst");
      @(negedge clk);
      rst = 1'b1;
      repeat (5) step();
      check("post-reset done", longint'(done), 0);
      check("post-reset busy", longint'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

endmodule
